bht_controller: RTL and testbench
=================================

BHT_CONTROLLER -- requirements
Module: bht_controller

Interface
REQ-001 Parameter DEPTH, default 4, in-flight branch FIFO depth (power of two, 2..16).
REQ-002 Parameter CW, default 16, width of the misprediction counter.
REQ-003 clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 branch_valid  in  1  fetch stage requests a prediction.
REQ-006 branch_addr  in  11  branch address for the request.
REQ-007 branch_ready  out  1  request accepted on this edge when high with branch_valid.
REQ-008 resolve_valid  in  1  execute stage reports the oldest in-flight branch outcome.
REQ-009 resolve_taken  in  1  actual outcome (1 = taken).
REQ-010 resolve_ready  out  1  resolution accepted on this edge when high with resolve_valid.
REQ-011 prediction_in  in  1  prediction bit returned by the predictor table.
REQ-012 latched_branch_addr  out  11  lookup address to the predictor.
REQ-013 predict_strobe  out  1  registered pulse driving the predictor lookup clock.
REQ-014 fifo_branch_addr  out  11  update address to the predictor.
REQ-015 branch_result  out  1  outcome to the predictor update port.
REQ-016 update_strobe  out  1  registered pulse driving the predictor update clock.
REQ-017 prediction  out  1  prediction returned to fetch; prediction_valid  out  1  one-cycle qualifier.
REQ-018 mispredict  out  1  one-cycle pulse; mispredict_count  out  CW  saturating count.
REQ-019 occupancy  out  clog2(DEPTH)+1  in-flight entries; resolve_error  out  1  sticky underflow flag.

Function
REQ-020 FSM states: IDLE, P_SETUP, P_STROBE, P_CAPTURE, U_SETUP, U_STROBE; one operation at a time; predict_strobe and update_strobe SHALL never be high in the same cycle.
REQ-021 resolve_ready = (state==IDLE) and occupancy!=0.
REQ-022 branch_ready = (state==IDLE) and occupancy!=DEPTH and not(resolve_valid and resolve_ready); update wins on simultaneous requests.
REQ-023 Branch accept (edge E0): latched_branch_addr<=branch_addr, go P_SETUP.
REQ-024 E1: predict_strobe<=1, go P_STROBE; E2: predict_strobe<=0, go P_CAPTURE.
REQ-025 E3: prediction<=prediction_in, prediction_valid<=1 for one cycle, push {latched_branch_addr, prediction_in} to FIFO, occupancy+1, go IDLE; next request acceptable at E3+1 (4-cycle throughput).
REQ-026 Resolve accept (E0): fifo_branch_addr<=head address, branch_result<=resolve_taken, go U_SETUP.
REQ-027 E1: update_strobe<=1, go U_STROBE; E2: update_strobe<=0, pop head, occupancy-1, go IDLE.
REQ-028 At E2 of an update, mispredict<=1 for one cycle when branch_result differs from the stored head prediction bit; mispredict_count increments, holding at 2^CW-1.
REQ-029 Addresses SHALL be stable one full cycle before and during each strobe pulse.
REQ-030 resolve_valid while occupancy==0 and state==IDLE: no update, resolve_error<=1 (sticky until reset).
REQ-031 branch_valid while full: held off, no strobe, no state change.
REQ-032 FIFO pointers wrap modulo DEPTH; order strictly first-in first-out.
REQ-033 Inputs outside IDLE are ignored (ready low).

Reset
REQ-034 reset_n low SHALL immediately force state IDLE, FIFO empty, all outputs 0 (addresses 0, strobes 0, counter 0, resolve_error 0).
REQ-035 Reset mid-operation drops an active strobe asynchronously and discards any in-flight entry; first accept allowed on the first rising edge after reset_n high.

Verification
REQ-036 Request addr 0x155, prediction_in=1 -> predict_strobe high exactly E1-E2, prediction=1 with prediction_valid at E3, occupancy=1.
REQ-037 Fill 4 requests, hold branch_valid -> branch_ready low, occupancy=4; one resolve -> update to first address, occupancy=3, then request accepted.
REQ-038 Simultaneous branch_valid and resolve_valid with occupancy=2 -> update issued first, predict follows at earliest IDLE; strobes never overlap.
REQ-039 Stored prediction 1, resolve_taken=0 -> mispredict pulse, mispredict_count=1; matching outcome -> no pulse.
REQ-040 resolve_valid with empty FIFO -> no update_strobe, resolve_error=1 held until reset.
REQ-041 Assert reset_n low during P_STROBE -> predict_strobe falls without clock edge, occupancy=0, all outputs 0.

Source files
------------

// File: rtl/bht_controller.sv
// ============================================================================
// Module   : bht_controller
// Brief    : Sequences predictor lookups and updates for in-flight branches,
//            tracking them in order and counting mispredictions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_controller #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     branch_valid,
    input  logic [10:0]              branch_addr,
    output logic                     branch_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    input  logic                     prediction_in,
    output logic [10:0]              latched_branch_addr,
    output logic                     predict_strobe,
    output logic [10:0]              fifo_branch_addr,
    output logic                     branch_result,
    output logic                     update_strobe,
    output logic                     prediction,
    output logic                     prediction_valid,
    output logic                     mispredict,
    output logic [CW-1:0]            mispredict_count,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     resolve_error
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P_SETUP   = 3'd1,
        P_STROBE  = 3'd2,
        P_CAPTURE = 3'd3,
        U_SETUP   = 3'd4,
        U_STROBE  = 3'd5
    } state_t;

    state_t state, state_next;

    logic [10:0]   addr_mem [DEPTH];
    logic          pred_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic accept_resolve, accept_branch;

    assign resolve_ready  = (state == IDLE) && (occupancy != '0);
    assign branch_ready   = (state == IDLE) && (occupancy != FULL) &&
                            !(resolve_valid && resolve_ready);
    assign accept_resolve = resolve_valid && resolve_ready;
    assign accept_branch  = branch_valid && branch_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_resolve)     state_next = U_SETUP;
                else if (accept_branch) state_next = P_SETUP;
            end
            P_SETUP:   state_next = P_STROBE;
            P_STROBE:  state_next = P_CAPTURE;
            P_CAPTURE: state_next = IDLE;
            U_SETUP:   state_next = U_STROBE;
            U_STROBE:  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (state == P_CAPTURE) begin
            addr_mem[wr_ptr] <= latched_branch_addr;
            pred_mem[wr_ptr] <= prediction_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latched_branch_addr <= '0;
            predict_strobe      <= 1'b0;
            fifo_branch_addr    <= '0;
            branch_result       <= 1'b0;
            update_strobe       <= 1'b0;
            prediction          <= 1'b0;
            prediction_valid    <= 1'b0;
            mispredict          <= 1'b0;
            mispredict_count    <= '0;
            occupancy           <= '0;
            resolve_error       <= 1'b0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
        end else begin
            prediction_valid <= 1'b0;
            mispredict       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_resolve) begin
                        fifo_branch_addr <= addr_mem[rd_ptr];
                        branch_result    <= resolve_taken;
                    end else if (accept_branch) begin
                        latched_branch_addr <= branch_addr;
                    end
                    if (resolve_valid && (occupancy == '0))
                        resolve_error <= 1'b1;
                end
                P_SETUP:  predict_strobe <= 1'b1;
                P_STROBE: predict_strobe <= 1'b0;
                P_CAPTURE: begin
                    prediction       <= prediction_in;
                    prediction_valid <= 1'b1;
                    wr_ptr           <= wr_ptr + 1'b1;
                    occupancy        <= occupancy + 1'b1;
                end
                U_SETUP: update_strobe <= 1'b1;
                U_STROBE: begin
                    update_strobe <= 1'b0;
                    rd_ptr        <= rd_ptr + 1'b1;
                    occupancy     <= occupancy - 1'b1;
                    if (branch_result != pred_mem[rd_ptr]) begin
                        mispredict <= 1'b1;
                        if (mispredict_count != {CW{1'b1}})
                            mispredict_count <= mispredict_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bht_controller.sv
// ============================================================================
// Module   : tb_bht_controller
// Brief    : Directed self-checking bench for bht_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bht_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        branch_valid, resolve_valid, resolve_taken, prediction_in;
    logic [10:0] branch_addr;
    logic        branch_ready, resolve_ready;
    logic [10:0] latched_branch_addr, fifo_branch_addr;
    logic        predict_strobe, update_strobe, branch_result;
    logic        prediction, prediction_valid, mispredict, resolve_error;
    logic [15:0] mispredict_count;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    bht_controller #(.DEPTH(4), .CW(16)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .branch_valid        (branch_valid),
        .branch_addr         (branch_addr),
        .branch_ready        (branch_ready),
        .resolve_valid       (resolve_valid),
        .resolve_taken       (resolve_taken),
        .resolve_ready       (resolve_ready),
        .prediction_in       (prediction_in),
        .latched_branch_addr (latched_branch_addr),
        .predict_strobe      (predict_strobe),
        .fifo_branch_addr    (fifo_branch_addr),
        .branch_result       (branch_result),
        .update_strobe       (update_strobe),
        .prediction          (prediction),
        .prediction_valid    (prediction_valid),
        .mispredict          (mispredict),
        .mispredict_count    (mispredict_count),
        .occupancy           (occupancy),
        .resolve_error       (resolve_error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) check_eq("strobe_overlap", 32'(predict_strobe & update_strobe), 0);

    task automatic do_predict(input logic [10:0] addr, input logic pin, input logic [2:0] exp_occ);
        branch_addr   = addr;
        prediction_in = pin;
        branch_valid  = 1'b1;
        tick();
        branch_valid  = 1'b0;
        check_eq("pred_latch", 32'(latched_branch_addr), 32'(addr));
        tick();
        tick();
        tick();
        check_eq("pred_value", 32'(prediction), 32'(pin));
        check_eq("pred_valid", 32'(prediction_valid), 1);
        check_eq("pred_occ", 32'(occupancy), 32'(exp_occ));
    endtask

    task automatic do_resolve(input logic taken, input logic [10:0] exp_addr, input logic exp_mis);
        resolve_taken = taken;
        resolve_valid = 1'b1;
        tick();
        resolve_valid = 1'b0;
        check_eq("upd_addr", 32'(fifo_branch_addr), 32'(exp_addr));
        check_eq("upd_result", 32'(branch_result), 32'(taken));
        tick();
        check_eq("upd_strobe_hi", 32'(update_strobe), 1);
        tick();
        check_eq("upd_strobe_lo", 32'(update_strobe), 0);
        check_eq("upd_mispredict", 32'(mispredict), 32'(exp_mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        branch_valid  = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        prediction_in = 1'b0;
        branch_addr   = '0;
        #1;
        check_eq("rst_pstrobe", 32'(predict_strobe), 0);
        check_eq("rst_occ", 32'(occupancy), 0);
        check_eq("rst_latched", 32'(latched_branch_addr), 0);
        check_eq("rst_count", 32'(mispredict_count), 0);
        check_eq("rst_error", 32'(resolve_error), 0);
        #21;
        reset_n = 1'b1;

        // Single lookup at 0x155
        branch_addr   = 11'h155;
        prediction_in = 1'b1;
        branch_valid  = 1'b1;
        #1;
        check_eq("a_bready", 32'(branch_ready), 1);
        tick();
        branch_valid = 1'b0;
        check_eq("a_latched", 32'(latched_branch_addr), 32'h155);
        check_eq("a_e0_strobe", 32'(predict_strobe), 0);
        tick();
        check_eq("a_e1_strobe", 32'(predict_strobe), 1);
        tick();
        check_eq("a_e2_strobe", 32'(predict_strobe), 0);
        check_eq("a_e2_pvalid", 32'(prediction_valid), 0);
        tick();
        check_eq("a_pred", 32'(prediction), 1);
        check_eq("a_pvalid", 32'(prediction_valid), 1);
        check_eq("a_occ", 32'(occupancy), 1);
        tick();
        check_eq("a_pvalid_drop", 32'(prediction_valid), 0);

        // Fill to full, hold off a further request
        do_predict(11'h0A1, 1'b0, 3'd2);
        do_predict(11'h2B2, 1'b1, 3'd3);
        do_predict(11'h3C3, 1'b0, 3'd4);
        branch_addr   = 11'h444;
        prediction_in = 1'b1;
        branch_valid  = 1'b1;
        #1;
        check_eq("full_bready", 32'(branch_ready), 0);
        tick();
        tick();
        check_eq("full_occ", 32'(occupancy), 4);
        check_eq("full_nostrobe", 32'(predict_strobe), 0);
        check_eq("full_latched", 32'(latched_branch_addr), 32'h3C3);

        // Resolve oldest (stored 1, actual 0) while request still held
        resolve_taken = 1'b0;
        resolve_valid = 1'b1;
        #1;
        check_eq("full_rready", 32'(resolve_ready), 1);
        tick();
        resolve_valid = 1'b0;
        check_eq("r1_addr", 32'(fifo_branch_addr), 32'h155);
        tick();
        check_eq("r1_ustrobe", 32'(update_strobe), 1);
        tick();
        check_eq("r1_ustrobe_lo", 32'(update_strobe), 0);
        check_eq("r1_mispredict", 32'(mispredict), 1);
        check_eq("r1_count", 32'(mispredict_count), 1);
        check_eq("r1_occ", 32'(occupancy), 3);
        check_eq("r1_bready", 32'(branch_ready), 1);
        tick();
        branch_valid = 1'b0;
        check_eq("r1_next_latched", 32'(latched_branch_addr), 32'h444);
        check_eq("r1_mis_pulse", 32'(mispredict), 0);
        tick();
        tick();
        tick();
        check_eq("r1_refill_occ", 32'(occupancy), 4);

        do_resolve(1'b0, 11'h0A1, 1'b0);
        check_eq("r2_count", 32'(mispredict_count), 1);
        do_resolve(1'b0, 11'h2B2, 1'b1);
        check_eq("r3_count", 32'(mispredict_count), 2);
        check_eq("r3_occ", 32'(occupancy), 2);

        // Simultaneous requests: update wins
        branch_addr   = 11'h555;
        prediction_in = 1'b0;
        branch_valid  = 1'b1;
        resolve_taken = 1'b0;
        resolve_valid = 1'b1;
        #1;
        check_eq("sim_rready", 32'(resolve_ready), 1);
        check_eq("sim_bready", 32'(branch_ready), 0);
        tick();
        resolve_valid = 1'b0;
        check_eq("sim_uaddr", 32'(fifo_branch_addr), 32'h3C3);
        check_eq("sim_latched_hold", 32'(latched_branch_addr), 32'h444);
        tick();
        check_eq("sim_ustrobe", 32'(update_strobe), 1);
        tick();
        check_eq("sim_occ1", 32'(occupancy), 1);
        check_eq("sim_nomis", 32'(mispredict), 0);
        tick();
        branch_valid = 1'b0;
        check_eq("sim_latched", 32'(latched_branch_addr), 32'h555);
        tick();
        check_eq("sim_pstrobe", 32'(predict_strobe), 1);
        tick();
        tick();
        check_eq("sim_occ2", 32'(occupancy), 2);
        check_eq("sim_pred", 32'(prediction), 0);
        check_eq("sim_pvalid", 32'(prediction_valid), 1);

        // Drain across the pointer wrap
        do_resolve(1'b1, 11'h444, 1'b0);
        do_resolve(1'b1, 11'h555, 1'b1);
        check_eq("drain_count", 32'(mispredict_count), 3);
        check_eq("drain_occ", 32'(occupancy), 0);

        // Resolve with nothing in flight
        resolve_taken = 1'b1;
        resolve_valid = 1'b1;
        #1;
        check_eq("uf_rready", 32'(resolve_ready), 0);
        tick();
        check_eq("uf_error", 32'(resolve_error), 1);
        check_eq("uf_nostrobe", 32'(update_strobe), 0);
        tick();
        check_eq("uf_nostrobe2", 32'(update_strobe), 0);
        resolve_valid = 1'b0;
        tick();
        check_eq("uf_sticky", 32'(resolve_error), 1);
        check_eq("uf_occ", 32'(occupancy), 0);

        // Asynchronous reset during P_STROBE
        branch_addr   = 11'h2AA;
        prediction_in = 1'b1;
        branch_valid  = 1'b1;
        tick();
        branch_valid = 1'b0;
        tick();
        check_eq("ar_pstrobe_hi", 32'(predict_strobe), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_pstrobe", 32'(predict_strobe), 0);
        check_eq("ar_occ", 32'(occupancy), 0);
        check_eq("ar_latched", 32'(latched_branch_addr), 0);
        check_eq("ar_error", 32'(resolve_error), 0);
        check_eq("ar_count", 32'(mispredict_count), 0);
        check_eq("ar_pred", 32'(prediction), 0);
        check_eq("ar_faddr", 32'(fifo_branch_addr), 0);
        check_eq("ar_result", 32'(branch_result), 0);
        #3;
        reset_n       = 1'b1;
        branch_addr   = 11'h123;
        prediction_in = 1'b1;
        branch_valid  = 1'b1;
        #1;
        check_eq("ar_bready", 32'(branch_ready), 1);
        tick();
        branch_valid = 1'b0;
        check_eq("ar_first_accept", 32'(latched_branch_addr), 32'h123);
        tick();
        tick();
        tick();
        check_eq("ar_occ1", 32'(occupancy), 1);
        check_eq("ar_pred1", 32'(prediction), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
